// File: rtl/controller_sequencer.sv
// Control unit for a SAP-style 8-bit CPU: a six-state one-hot ring (T1..T6) plus a
// halted flag; all datapath controls decode from the registered T-state and the opcode.
module controller_sequencer (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] tstate
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    t_state_e state_q, state_d;
    logic     halted_q, halted_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: every signal driven below gets a default before any branching, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = T1;
        halted_d = halted_q;
        cp = 1'b0; ep = 1'b0; lm = 1'b0; ce = 1'b0;
        li = 1'b0; ei = 1'b0; la = 1'b0; ea = 1'b0;
        su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
        hlt = 1'b0;

        if (halted_q) begin
            state_d = state_q;
        end else begin
            case (state_q)
                T1: state_d = T2;
                T2: state_d = T3;
                T3: state_d = T4;
                T4: begin
                    if (opcode == OP_HLT) begin
                        state_d  = T4;
                        halted_d = 1'b1;
                    end else begin
                        state_d = T5;
                    end
                end
                T5: state_d = T6;
                T6: state_d = T1;
                // Any non-one-hot ring value recovers to T1 on the next edge.
                default: state_d = T1;
            endcase
        end

        if (!clr && !halted_q) begin
            case (state_q)
                T1: begin ep = 1'b1; lm = 1'b1; end
                T2: cp = 1'b1;
                T3: begin ce = 1'b1; li = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_OUT:                 begin ea = 1'b1; lo = 1'b1; end
                        OP_HLT:                 hlt = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; end
                        OP_SUB: begin eu = 1'b1; la = 1'b1; su = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        if (!clr && halted_q) begin
            hlt = 1'b1;
        end
    end

    assign tstate = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: stimulus pushes per-cycle expected control
// words, a negedge monitor pops and compares them against the DUT outputs.
module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] tstate;

    controller_sequencer dut (
        .clk(clk), .clr(clr), .opcode(opcode),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
        .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
        .hlt(hlt), .tstate(tstate)
    );

    always #5 clk = ~clk;

    // Control word order: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
    localparam logic [12:0] C_CP  = 13'h1000;
    localparam logic [12:0] C_EP  = 13'h0800;
    localparam logic [12:0] C_LM  = 13'h0400;
    localparam logic [12:0] C_CE  = 13'h0200;
    localparam logic [12:0] C_LI  = 13'h0100;
    localparam logic [12:0] C_EI  = 13'h0080;
    localparam logic [12:0] C_LA  = 13'h0040;
    localparam logic [12:0] C_EA  = 13'h0020;
    localparam logic [12:0] C_SU  = 13'h0010;
    localparam logic [12:0] C_EU  = 13'h0008;
    localparam logic [12:0] C_LB  = 13'h0004;
    localparam logic [12:0] C_LO  = 13'h0002;
    localparam logic [12:0] C_HLT = 13'h0001;
    localparam logic [12:0] C_NONE = 13'h0000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct {
        string       name;
        logic [12:0] ctl;
        logic [5:0]  ts;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    logic [12:0] act_ctl;
    assign act_ctl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    endtask

    // Monitor: compares whatever cycle the DUT is presenting against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, "_ctl"}, 32'(act_ctl), 32'(e.ctl));
            check({e.name, "_ts"},  32'(tstate),  32'(e.ts));
            check({e.name, "_onehot"}, 32'($countones(tstate)), 32'd1);
            check({e.name, "_bus"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
            check({e.name, "_ldenb"}, 32'((li & ei) | (la & ea)), 32'd0);
        end
    end

    // Applies inputs for the current cycle, queues its expected outputs, moves to next cycle.
    task automatic step(input logic c, input logic [3:0] op, input logic [12:0] ctl,
                        input logic [5:0] ts, input string nm);
        exp_t e;
        clr    = c;
        opcode = op;
        e.name = nm;
        e.ctl  = ctl;
        e.ts   = ts;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [12:0] c4, input logic [12:0] c5,
                         input logic [12:0] c6, input string nm);
        step(1'b0, op, C_EP | C_LM, T1, {nm, "_t1"});
        step(1'b0, op, C_CP,        T2, {nm, "_t2"});
        step(1'b0, op, C_CE | C_LI, T3, {nm, "_t3"});
        step(1'b0, op, c4,          T4, {nm, "_t4"});
        step(1'b0, op, c5,          T5, {nm, "_t5"});
        step(1'b0, op, c6,          T6, {nm, "_t6"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 4'b0000, C_NONE, T1, "rst0");
        step(1'b1, 4'b0000, C_NONE, T1, "rst1");

        instr(4'b0000, C_EI | C_LM, C_CE | C_LA, C_NONE, "lda");
        instr(4'b0001, C_EI | C_LM, C_CE | C_LB, C_EU | C_LA, "add");
        instr(4'b0010, C_EI | C_LM, C_CE | C_LB, C_EU | C_LA | C_SU, "sub");
        instr(4'b1110, C_EA | C_LO, C_NONE, C_NONE, "out");
        instr(4'b0111, C_NONE, C_NONE, C_NONE, "nop");
        instr(4'b0000, C_EI | C_LM, C_CE | C_LA, C_NONE, "lda2");

        // HLT: asserted in T4, then frozen at T4 with only hlt high; opcode is ignored.
        step(1'b0, 4'b1111, C_EP | C_LM, T1, "hlt_t1");
        step(1'b0, 4'b1111, C_CP,        T2, "hlt_t2");
        step(1'b0, 4'b1111, C_CE | C_LI, T3, "hlt_t3");
        step(1'b0, 4'b1111, C_HLT,       T4, "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'(i), C_HLT, T4, "halted");
        end
        step(1'b1, 4'b0001, C_NONE,      T4, "hlt_clr");
        step(1'b0, 4'b0001, C_EP | C_LM, T1, "post_hlt_t1");
        step(1'b0, 4'b0001, C_CP,        T2, "post_hlt_t2");
        step(1'b0, 4'b0001, C_CE | C_LI, T3, "post_hlt_t3");
        step(1'b0, 4'b0001, C_EI | C_LM, T4, "post_hlt_t4");

        // clr in T5 of ADD: outputs forced low that cycle, then back to T1.
        step(1'b1, 4'b0001, C_NONE,      T5, "midclr_t5");
        step(1'b0, 4'b0001, C_EP | C_LM, T1, "midclr_t1");
        step(1'b0, 4'b0001, C_CP,        T2, "midclr_t2");

        repeat (3) @(posedge clk);
        check("drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
